riscv_muldiv_unit: RTL and testbench
====================================

Name: riscv_muldiv_unit

Overview:
Iterative RV32M/RV64M multiply/divide unit, parametrised in operand width, beside the existing ALU in the execute stage. The single-cycle ALU has no M-extension support. This block adds all eight M-extension operations using a shift-add multiplier and a restoring divider, one bit per clock. The core talks to it through a valid/ready handshake and stalls the PC while the unit is busy.

Parameters:
XLEN, 32, operand/result width (32 or 64)
CNT_W, $clog2(XLEN)+1, iteration counter width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
in_valid  input  1  operation request
in_ready  output  1  unit can accept a request
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src1  input  XLEN  rs1 value
src2  input  XLEN  rs2 value
flush  input  1  synchronous abort of the current operation
out_valid  output  1  result available
out_ready  input  1  consumer takes the result
result  output  XLEN  rd value
busy  output  1  high in CALC or DONE (PC stall)

Behaviour:
- Reset (reset=0) is asynchronous. It forces state=IDLE, out_valid=0, result=0, busy=0, counter=0 and all datapath registers to 0. in_ready=1 in the first cycle after release.
- FSM states are IDLE, CALC and DONE.
- in_ready = (state==IDLE) and not flush. A request is accepted on an edge where in_valid and in_ready are both high. funct3, src1 and src2 are captured on that edge.
- IDLE, accept, normal case: go to CALC, load counter=XLEN, load operand magnitudes and sign flags.
- IDLE, accept, special case: go directly to DONE with the result precomputed, so out_valid is high after 1 edge. Special cases are:
  - Divide by zero (src2==0): DIV/DIVU give all-ones; REM/REMU give src1.
  - Signed overflow (DIV/REM with src1 = most negative value and src2 = all-ones): DIV gives the most negative value; REM gives 0.
- CALC: one iteration per edge; the counter decrements each edge. When the counter reaches 0, go to DONE. out_valid is high exactly XLEN+1 edges after the accepting edge.
- Multiply:
  - Unsigned shift-add over |src1|, |src2| into a 2*XLEN accumulator.
  - Operands are signed as follows: MULH takes both signed; MULHSU takes src1 signed and src2 unsigned; MUL and MULHU take both unsigned. MUL gives the same low bits either way.
  - The 2*XLEN product is negated when the operand signs differ.
  - MUL returns bits [XLEN-1:0]; the others return [2*XLEN-1:XLEN].
- Divide:
  - Restoring division on magnitudes, with signed interpretation for DIV/REM only.
  - Quotient sign = sign1 XOR sign2.
  - Remainder sign = sign1, so the remainder is truncated toward zero (RISC-V semantics).
- DONE: out_valid=1 and result is held stable until an edge with out_ready=1. On that edge go to IDLE; out_valid falls after the edge and in_ready rises. No new request is accepted in DONE.
- flush=1 on an edge in CALC or DONE: go to IDLE, out_valid=0, and the result is discarded. flush in IDLE is ignored, and in_ready is 0 while flush is high. flush takes priority over out_ready and in_valid.
- Reset asserted mid-operation: all outputs go to reset values immediately, without waiting for a clock edge; no partial result is ever presented.
- out_valid and busy are registered or state-decoded, with no combinational path from in_valid.
- result is registered and is only updated when entering DONE.

Test Plan:
- Multiply latency and sign: XLEN=32, MUL src1=7, src2=0xFFFFFFFD -> result 0xFFFFFFEB, out_valid exactly 33 edges after accept, busy high throughout.
- High-half multiplies: MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- Divide: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 0x0000000E. REMU 100/7 -> 0x00000002. Each with latency 33.
- Special cases, 1-edge latency: DIV 5/0 -> 0xFFFFFFFF. REMU 5/0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM same operands -> 0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 -> in_ready=1 on the next cycle, and a back-to-back request is accepted.
- Abort paths:
  - flush 10 edges into a DIVU -> IDLE on the next edge, no out_valid. The next MUL 3x4 returns 12.
  - reset=0 mid-CALC -> out_valid, busy and result go to 0 immediately.

Source files
------------

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiplier and restoring
// divider, one bit per clock, behind a valid/ready handshake.
module riscv_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        op_q;
    logic              negq_q, negr_q;
    logic [2*XLEN-1:0] a_q, p_q;
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   result_q;
    logic              out_valid_q;

    // Request decode
    logic              is_div, sgn_div, s1, s2, div0, ovf, special;
    logic [XLEN-1:0]   mag1, mag2, spec_res;

    always_comb begin
        is_div   = funct3[2];
        sgn_div  = is_div & ~funct3[0];
        s1       = is_div ? (sgn_div & src1[XLEN-1])
                          : (((funct3 == OP_MULH) || (funct3 == OP_MULHSU)) & src1[XLEN-1]);
        s2       = is_div ? (sgn_div & src2[XLEN-1])
                          : ((funct3 == OP_MULH) & src2[XLEN-1]);
        mag1     = s1 ? -src1 : src1;
        mag2     = s2 ? -src2 : src2;
        div0     = is_div && (src2 == '0);
        ovf      = sgn_div && (src1 == MOST_NEG) && (src2 == '1);
        special  = div0 | ovf;
        if (div0) spec_res = funct3[1] ? src1 : '1;
        else      spec_res = funct3[1] ? '0 : MOST_NEG;
    end

    // One iteration of the datapath plus the sign-corrected result of the last one
    logic [2*XLEN-1:0] a_d, p_d, prod_d;
    logic [XLEN-1:0]   b_d, quot_d, rem_d, fin_d;
    logic [XLEN:0]     rem_sh, diff;
    logic              ge;

    always_comb begin
        rem_sh = {p_q[XLEN-1:0], b_q[XLEN-1]};
        diff   = rem_sh - {1'b0, a_q[XLEN-1:0]};
        ge     = ~diff[XLEN];
        if (op_q[2]) begin
            a_d = a_q;
            b_d = {b_q[XLEN-2:0], ge};
            p_d = {{XLEN{1'b0}}, (ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0])};
        end else begin
            a_d = a_q << 1;
            b_d = b_q >> 1;
            p_d = p_q + (b_q[0] ? a_q : '0);
        end
        prod_d = negq_q ? -p_d : p_d;
        quot_d = negq_q ? -b_d : b_d;
        rem_d  = negr_q ? -p_d[XLEN-1:0] : p_d[XLEN-1:0];
        if (op_q[2])              fin_d = op_q[1] ? rem_d : quot_d;
        else if (op_q == OP_MUL)  fin_d = prod_d[XLEN-1:0];
        else                      fin_d = prod_d[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            p_q         <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && !flush) begin
                        op_q   <= funct3;
                        negq_q <= s1 ^ s2;
                        negr_q <= s1;
                        if (special) begin
                            result_q    <= spec_res;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            cnt_q   <= CNT_W'(XLEN);
                            a_q     <= {{XLEN{1'b0}}, (is_div ? mag2 : mag1)};
                            b_q     <= is_div ? mag1 : mag2;
                            p_q     <= '0;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        a_q   <= a_d;
                        b_q   <= b_d;
                        p_q   <= p_d;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            result_q    <= fin_d;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (flush || out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && !flush;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Scoreboard bench for riscv_muldiv_unit: directed M-extension vectors, latency,
// backpressure, flush and asynchronous reset.
module tb_riscv_muldiv_unit;

    localparam int XLEN = 32;
    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    logic            clk = 1'b0;
    logic            reset, in_valid, flush, out_ready;
    logic            in_ready, out_valid, busy;
    logic [2:0]      funct3;
    logic [XLEN-1:0] src1, src2, result;

    riscv_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .src1(src1), .src2(src2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [XLEN-1:0] res;
        int              lat;
        int              acc;
        string           name;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_seen = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: latency on first sight of out_valid, result on the consuming edge
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset && out_valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_out_valid", out_valid, 1'b0);
                end else begin
                    if (!mon_seen) begin
                        check({sbq[0].name, "_latency"}, cyc - sbq[0].acc, sbq[0].lat);
                        mon_seen = 1'b1;
                    end
                    if (out_ready) begin
                        check({sbq[0].name, "_result"}, result, sbq[0].res);
                        void'(sbq.pop_front());
                        mon_seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] res, input int lat, input bit push, input string name);
        int n;
        exp_t e;
        in_valid = 1'b1;
        funct3   = f;
        src1     = a;
        src2     = b;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) check({name, "_accept_timeout"}, in_ready, 1'b1);
        if (push) begin
            e.res = res; e.lat = lat; e.acc = cyc; e.name = name;
            sbq.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", sbq.size(), 0);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        funct3 = '0; src1 = '0; src2 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_result", result, 32'h0);
        @(negedge clk);

        // MUL latency, sign and busy over the whole calculation
        issue(MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b1, "mul_7_neg3");
        begin
            int lowb = 0;
            for (int i = 0; i < 32; i++) begin
                #1;
                if (!busy) lowb++;
                @(negedge clk);
            end
            check("mul_busy_low_cycles", lowb, 0);
        end
        drain();

        issue(MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33, 1'b1, "mulh_min_min");
        issue(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b1, "mulhu_max_max");
        issue(MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, 1'b1, "mulhsu_m1_2");
        issue(DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 1'b1, "div_m7_2");
        issue(REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 1'b1, "rem_m7_2");
        issue(DIVU,   32'd100,      32'd7,        32'h0000000E, 33, 1'b1, "divu_100_7");
        issue(REMU,   32'd100,      32'd7,        32'h00000002, 33, 1'b1, "remu_100_7");
        issue(DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1,  1'b1, "div_by_zero");
        issue(REMU,   32'd5,        32'd0,        32'h00000005, 1,  1'b1, "remu_by_zero");
        issue(DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  1'b1, "div_overflow");
        issue(REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  1'b1, "rem_overflow");
        drain();

        // Backpressure: result held, requests refused, then back-to-back accept
        out_ready = 1'b0;
        issue(DIVU, 32'd100, 32'd7, 32'h0000000E, 33, 1'b1, "bp_divu");
        begin
            int n = 0;
            #1;
            while (!out_valid && n < 100) begin
                @(negedge clk);
                #1;
                n++;
            end
            check("bp_out_valid", out_valid, 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; funct3 = MUL; src1 = 32'd9; src2 = 32'd9;
            #1;
            check($sformatf("bp_result_stable_%0d", i), result, 32'h0000000E);
            check($sformatf("bp_in_ready_low_%0d", i), in_ready, 1'b0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_in_ready_after", in_ready, 1'b1);
        check("bp_out_valid_after", out_valid, 1'b0);
        issue(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b1, "bp_back_to_back");
        drain();

        // Flush mid-DIVU: no result, next operation unaffected
        issue(DIVU, 32'd1000, 32'd3, 32'd0, 33, 1'b0, "flushed_divu");
        repeat (9) @(negedge clk);
        #1;
        check("flush_busy_before", busy, 1'b1);
        flush = 1'b1;
        #1;
        check("flush_in_ready_low", in_ready, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_busy_after", busy, 1'b0);
        check("flush_in_ready_after", in_ready, 1'b1);
        issue(MUL, 32'd3, 32'd4, 32'd12, 33, 1'b1, "mul_after_flush");
        drain();

        // Asynchronous reset mid-calculation
        issue(MUL, 32'd5, 32'd5, 32'd25, 33, 1'b0, "reset_mul");
        repeat (5) @(negedge clk);
        #1;
        check("arst_busy_before", busy, 1'b1);
        check("arst_result_before", result, 32'd12);
        reset = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_result", result, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_in_ready_after", in_ready, 1'b1);
        repeat (40) @(negedge clk);
        check("arst_queue_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
